// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_arbiter                                                 |
// | Brief  : Two-port (cpu / external loader) arbiter onto one memory.   |
// |          Round-robin on ties, ext_lock keeps the loader on the port, |
// |          one access per IDLE -> ACC -> ACK pass.                     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  input  logic          ext_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          take;
  logic          grant;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  // Arbitration: lock keeps ext on the port, otherwise ties go to the non-owner.
  always_comb begin
    take  = 1'b0;
    grant = owner;
    if (owner && ext_lock && ext_req) begin
      take  = 1'b1;
      grant = 1'b1;
    end else if (cpu_req && ext_req) begin
      take  = 1'b1;
      grant = ~owner;
    end else if (cpu_req) begin
      take  = 1'b1;
      grant = 1'b0;
    end else if (ext_req) begin
      take  = 1'b1;
      grant = 1'b1;
    end
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) state_nxt = ACC;
      end
      ACC: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        state_nxt = ACK;
      end
      ACK: begin
        cpu_ack   = ~owner;
        ext_ack   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture and read-data hold registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      owner       <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (state == IDLE && take) begin
        owner   <= grant;
        we_q    <= grant ? ext_we    : cpu_we;
        addr_q  <= grant ? ext_addr  : cpu_addr;
        wdata_q <= grant ? ext_wdata : cpu_wdata;
      end
      if (state == ACK && !we_q) begin
        if (owner) ext_rdata_q <= mem_rdata;
        else       cpu_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory returns data in the ACK cycle: pass it through while ack is high,
  // then the hold register keeps it until the owner's next read.
  assign cpu_rdata = (state == ACK && !owner && !we_q) ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = (state == ACK &&  owner && !we_q) ? mem_rdata : ext_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire
